bmem_arbiter: RTL

BMEM_ARBITER -- requirements
Module: bmem_arbiter

---
 rtl/rv32i_types.sv | 28 ++
 rtl/bmem_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared widths, states and helpers for the
// cache-to-burst-memory arbiter.
package rv32i_types;

  localparam int LINE_BITS = 256;
  localparam int BEATS     = LINE_BITS / 64;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    RESP
  } bmem_state_t;

  typedef enum logic {
    CLI_I = 1'b0,
    CLI_D = 1'b1
  } bmem_cli_t;

  // Burst memory works on 32-byte lines
  function automatic logic [31:0] line_align(
    input logic [31:0] a
  );
    return a & ~32'h0000_001f;
  endfunction

endpackage

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter between icache and dcache
// line requests onto a 64-bit burst memory.
module bmem_arbiter #(
  parameter int LINE_BITS = rv32i_types::LINE_BITS,
  parameter int BEATS     = rv32i_types::BEATS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_addr,
  input  logic                 i_read,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic [31:0]          d_addr,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [63:0]          bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [63:0]          bmem_rdata,
  input  logic                 bmem_rvalid
);

  import rv32i_types::*;

  localparam int CW =
    (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  bmem_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pref_i_q, pref_i_d;
  bmem_cli_t            cli_q, cli_d;
  logic [31:0]          addr_q, addr_d;
  logic [LINE_BITS-1:0] wline_q, wline_d;
  logic [LINE_BITS-1:0] buf_q, buf_d;
  logic [31:0]          line_a;
  logic                 d_req;
  bmem_cli_t            gnt;

  assign d_req   = d_read | d_write;
  assign line_a  = line_align(addr_q);
  assign i_rdata = buf_q;
  assign d_rdata = buf_q;

  // State, beat counter, fairness pointer and latched request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pref_i_q <= 1'b0;
      cli_q    <= CLI_I;
      addr_q   <= '0;
      wline_q  <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pref_i_q <= pref_i_d;
      cli_q    <= cli_d;
      addr_q   <= addr_d;
      wline_q  <= wline_d;
      buf_q    <= buf_d;
    end
  end

  // Grant, burst sequencing and memory/client outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pref_i_d   = pref_i_q;
    cli_d      = cli_q;
    addr_d     = addr_q;
    wline_d    = wline_q;
    buf_d      = buf_q;
    gnt        = CLI_D;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_read || d_req) begin
          if (i_read && d_req)
            gnt = pref_i_q ? CLI_I : CLI_D;
          else
            gnt = d_req ? CLI_D : CLI_I;
          cli_d    = gnt;
          pref_i_d = (gnt == CLI_D);
          cnt_d    = '0;
          if (gnt == CLI_D) begin
            addr_d  = d_addr;
            wline_d = d_wdata;
            state_d = d_write ? WR : RD_REQ;
          end else begin
            addr_d  = i_addr;
            wline_d = '0;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        bmem_addr = line_a;
        bmem_read = 1'b1;
        if (bmem_ready)
          state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Beats tagged for another line are not ours
        if (bmem_rvalid && bmem_raddr == line_a) begin
          for (int b = 0; b < BEATS; b++)
            if (cnt_q == CW'(b))
              buf_d[b*64 +: 64] = bmem_rdata;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WR: begin
        bmem_addr  = line_a;
        bmem_write = 1'b1;
        for (int b = 0; b < BEATS; b++)
          if (cnt_q == CW'(b))
            bmem_wdata = wline_q[b*64 +: 64];
        if (bmem_ready) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RESP: begin
        i_resp  = (cli_q == CLI_I);
        d_resp  = (cli_q == CLI_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
